// File: rtl/obc_supervisor_if.sv
// Verdict/escalation bundle between the OBC checker side and obc_supervisor.
// The checker drives the verdict strobe; the supervisor drives everything else.
interface obc_supervisor_if;
   logic       chk_valid;
   logic       chk_pass;
   logic       obc_reset;
   logic       override;
   logic       fault;
   logic [1:0] state;
   logic [3:0] fail_cnt;
   logic [1:0] reset_cnt;

   modport master (
      output chk_valid, chk_pass,
      input  obc_reset, override, fault, state, fail_cnt, reset_cnt
   );

   modport slave (
      input  chk_valid, chk_pass,
      output obc_reset, override, fault, state, fail_cnt, reset_cnt
   );
endinterface

// File: rtl/obc_supervisor.sv
// OBC supervisor: counts consecutive failed verdicts, pulses the primary OBC reset, then fails over.
// Define OBC_SUPERVISOR_TIMEOUT_EN to also count a missing verdict (silence for TIMEOUT_CYCLES) as a failure.
module obc_supervisor #(
   parameter int FAIL_LIMIT     = 3,
   parameter int GOOD_LIMIT     = 8,
   parameter int MAX_RESETS     = 2,
   parameter int RESET_CYCLES   = 16,
   parameter int HOLDOFF_CYCLES = 64,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic            clk,
   input  logic            reset,
   obc_supervisor_if.slave bus
);

   localparam logic [1:0] MONITOR   = 2'b00;
   localparam logic [1:0] RESET_OBC = 2'b01;
   localparam logic [1:0] HOLDOFF   = 2'b10;
   localparam logic [1:0] FAILOVER  = 2'b11;

   localparam int MAX_RH    = (RESET_CYCLES > HOLDOFF_CYCLES) ? RESET_CYCLES : HOLDOFF_CYCLES;
   localparam int MAX_PHASE = (MAX_RH > TIMEOUT_CYCLES) ? MAX_RH : TIMEOUT_CYCLES;
   localparam int TW        = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

   logic [1:0]    state_q, state_d;
   logic [3:0]    failCnt_q, failCnt_d;
   logic [3:0]    goodCnt_q, goodCnt_d;
   logic [1:0]    resetCnt_q, resetCnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          fault_q, fault_d;
   logic          obcReset_q;
   logic          override_q;
   logic          timeoutExp;
   logic          failure;

`ifdef OBC_SUPERVISOR_TIMEOUT_EN
   assign timeoutExp = (state_q == MONITOR) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeoutExp = 1'b0;
`endif

   // A verdict in the expiry cycle wins over the timeout.
   assign failure = bus.chk_valid ? !bus.chk_pass : timeoutExp;

   always_comb begin
      state_d    = state_q;
      failCnt_d  = failCnt_q;
      goodCnt_d  = goodCnt_q;
      resetCnt_d = resetCnt_q;
      timer_d    = timer_q;
      fault_d    = 1'b0;

      case (state_q)
         MONITOR: begin
`ifdef OBC_SUPERVISOR_TIMEOUT_EN
            timer_d = (bus.chk_valid || timeoutExp) ? '0 : timer_q + 1'b1;
`endif
            if (bus.chk_valid && bus.chk_pass) begin
               failCnt_d = 4'd0;
               if (({1'b0, goodCnt_q} + 5'd1) >= 5'(GOOD_LIMIT)) begin
                  goodCnt_d  = 4'd0;
                  resetCnt_d = 2'd0;
               end else begin
                  goodCnt_d = goodCnt_q + 4'd1;
               end
            end else if (failure) begin
               goodCnt_d = 4'd0;
               fault_d   = 1'b1;
               if (({1'b0, failCnt_q} + 5'd1) >= 5'(FAIL_LIMIT)) begin
                  failCnt_d = 4'd0;
                  timer_d   = '0;
                  if ({30'd0, resetCnt_q} < MAX_RESETS) begin
                     resetCnt_d = (resetCnt_q == 2'd3) ? 2'd3 : resetCnt_q + 2'd1;
                     state_d    = RESET_OBC;
                  end else begin
                     state_d = FAILOVER;
                  end
               end else begin
                  failCnt_d = failCnt_q + 4'd1;
               end
            end
         end

         RESET_OBC: begin
            if (timer_q == TW'(RESET_CYCLES - 1)) begin
               timer_d = '0;
               state_d = HOLDOFF;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         HOLDOFF: begin
            if (timer_q == TW'(HOLDOFF_CYCLES - 1)) begin
               timer_d = '0;
               state_d = MONITOR;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= MONITOR;
         failCnt_q  <= 4'd0;
         goodCnt_q  <= 4'd0;
         resetCnt_q <= 2'd0;
         timer_q    <= '0;
         fault_q    <= 1'b0;
         obcReset_q <= 1'b0;
         override_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         failCnt_q  <= failCnt_d;
         goodCnt_q  <= goodCnt_d;
         resetCnt_q <= resetCnt_d;
         timer_q    <= timer_d;
         fault_q    <= fault_d;
         obcReset_q <= (state_d == RESET_OBC);
         override_q <= (state_d == FAILOVER);
      end
   end

   assign bus.state     = state_q;
   assign bus.fail_cnt  = failCnt_q;
   assign bus.reset_cnt = resetCnt_q;
   assign bus.fault     = fault_q;
   assign bus.obc_reset = obcReset_q;
   assign bus.override  = override_q;

endmodule
